state_writer: RTL and testbench
===============================

STATE_WRITER -- requirements
Module: state_writer

Interface
REQ-001 Parameter GRID_W, default 80, grid width in cells.
REQ-002 Parameter GRID_H, default 60, grid height in cells; cell address = y*GRID_W + x, range 0..4799.
REQ-003 aclk  input  1  sole clock; all logic on rising edge.
REQ-004 aresetn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to compute one generation; sampled only in IDLE.
REQ-006 rd_addr  output  13  current-generation memory read address.
REQ-007 rd_data  input  1  cell state for rd_addr, valid exactly one cycle after rd_addr (synchronous read).
REQ-008 wr_en  output  1  next-generation memory write strobe.
REQ-009 wr_addr  output  13  next-generation write address.
REQ-010 wr_data  output  1  next-generation cell state.
REQ-011 busy  output  1  high while a generation is in progress.
REQ-012 done  output  1  one-cycle pulse at generation end.
REQ-013 gen_count  output  16  completed generations, wraps 65535->0.

Function
REQ-014 FSM states SHALL be IDLE, READ, WAIT, WRITE, DONE; all outputs SHALL be registered.
REQ-015 IDLE with start=1 (cycle 0) SHALL move to READ with cell index 0; busy=1 from cycle 1 through the last WRITE cycle.
REQ-016 READ SHALL last 9 cycles, issuing rd_addr for neighbours in order (dy,dx) = (-1,-1),(-1,0),(-1,+1),(0,-1),(0,0),(0,+1),(+1,-1),(+1,0),(+1,+1).
REQ-017 Neighbour coordinates SHALL wrap toroidally: x-1 at x=0 -> GRID_W-1, x+1 at GRID_W-1 -> 0; same for y with GRID_H-1.
REQ-018 WAIT (1 cycle) SHALL capture the 9th rd_data; the neighbour count (excluding (0,0)) SHALL be a 4-bit value, 0..8, and self SHALL be captured separately.
REQ-019 WRITE (1 cycle) SHALL assert wr_en=1, wr_addr = cell index, wr_data = 1 iff count==3 or (self==1 and count==2).
REQ-020 Cell n SHALL occupy cycles 11n+1..11n+11, with its write in cycle 11n+11; cells SHALL be processed in ascending address order, x fastest.
REQ-021 After WRITE of cell 4799 (cycle 52800), DONE SHALL assert done=1 for one cycle (cycle 52801), increment gen_count, and return to IDLE.
REQ-022 start in any state other than IDLE, including DONE, SHALL be ignored.
REQ-023 wr_en SHALL be 0 in every state except WRITE; exactly 4800 writes per generation.
REQ-024 rd_addr SHALL hold 0 in IDLE and DONE.

Reset
REQ-025 aresetn=0 SHALL immediately force IDLE, cell index 0, count 0, rd_addr 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, gen_count 0.
REQ-026 Reset mid-generation SHALL abandon the generation without further writes; the next accepted start SHALL begin at cell 0.

Verification
REQ-027 Blinker: alive (10,20),(11,20),(12,20), start -> written alive set exactly (11,19),(11,20),(11,21); done at cycle 52801; gen_count=1.
REQ-028 Torus-corner block: alive (0,0),(79,0),(0,59),(79,59) -> same four alive, all others 0 (verifies wrap).
REQ-029 Empty grid: start -> 4800 wr_en pulses, addresses 0..4799 in order, all wr_data=0, busy high cycles 1..52800.
REQ-030 Reset: aresetn low at cycle 1000 -> wr_en, busy, done 0 immediately, gen_count 0; no writes until a new start; restart completes in 52801 cycles.
REQ-031 start pulsed at cycles 5000 and 52801 (DONE) -> both ignored; gen_count increments once.
REQ-032 Birth/survival table: cell with 0..8 neighbours, self 0 and 1 -> wr_data=1 only for (self 0, 3), (self 1, 2), (self 1, 3).

Source files
------------

// File: rtl/state_writer.sv
// Game-of-Life generation engine: streams each cell's 3x3 torus neighbourhood
// out of a synchronous-read memory and writes the next-generation state.
module state_writer #(
  parameter int GRID_W = 80,
  parameter int GRID_H = 60
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  output logic [12:0] rd_addr,
  input  logic        rd_data,
  output logic        wr_en,
  output logic [12:0] wr_addr,
  output logic        wr_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] gen_count
);

  localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam logic [XW-1:0] X_MAX     = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(GRID_H - 1);
  localparam logic [12:0]   LAST_CELL = 13'(GRID_W * GRID_H - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  state_t        state_reg, state_next;
  logic [XW-1:0] x_reg, x_next;
  logic [YW-1:0] y_reg, y_next;
  logic [12:0]   cell_reg, cell_next;
  logic [3:0]    tap_reg, tap_next;
  logic [3:0]    count_reg, count_next;
  logic          self_reg, self_next;
  logic [12:0]   rd_addr_reg, rd_addr_next;
  logic          wr_en_reg, wr_en_next;
  logic [12:0]   wr_addr_reg, wr_addr_next;
  logic          wr_data_reg, wr_data_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic [15:0]   gen_reg, gen_next;
  logic [3:0]    total;

  // Tap 0..8 walks rows dy=-1,0,+1 and within each row dx=-1,0,+1, wrapping on the torus.
  function automatic logic [12:0] tap_addr(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                           input logic [3:0] tap);
    logic [XW-1:0] xx;
    logic [YW-1:0] yy;
    xx = x;
    yy = y;
    case (tap)
      4'd0, 4'd3, 4'd6: xx = (x == '0) ? X_MAX : x - 1'b1;
      4'd2, 4'd5, 4'd8: xx = (x == X_MAX) ? '0 : x + 1'b1;
      default: xx = x;
    endcase
    case (tap)
      4'd0, 4'd1, 4'd2: yy = (y == '0) ? Y_MAX : y - 1'b1;
      4'd6, 4'd7, 4'd8: yy = (y == Y_MAX) ? '0 : y + 1'b1;
      default: yy = y;
    endcase
    return 13'(yy) * 13'(GRID_W) + 13'(xx);
  endfunction

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg   <= IDLE;
      x_reg       <= '0;
      y_reg       <= '0;
      cell_reg    <= '0;
      tap_reg     <= '0;
      count_reg   <= '0;
      self_reg    <= 1'b0;
      rd_addr_reg <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      gen_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      cell_reg    <= cell_next;
      tap_reg     <= tap_next;
      count_reg   <= count_next;
      self_reg    <= self_next;
      rd_addr_reg <= rd_addr_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      gen_reg     <= gen_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    cell_next    = cell_reg;
    tap_next     = tap_reg;
    count_next   = count_reg;
    self_next    = self_reg;
    rd_addr_next = '0;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    gen_next     = gen_reg;
    total        = count_reg + {3'b000, rd_data};

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = READ;
          x_next     = '0;
          y_next     = '0;
          cell_next  = '0;
          tap_next   = '0;
          count_next = '0;
          self_next  = 1'b0;
          busy_next  = 1'b1;
        end
      end
      READ: begin
        // rd_data trails rd_addr by one cycle, so it belongs to tap_reg-1; tap 4 is the cell itself.
        if (tap_reg == 4'd5)
          self_next = rd_data;
        else if (tap_reg != 4'd0)
          count_next = total;
        if (tap_reg == 4'd8)
          state_next = WAIT;
        else
          tap_next = tap_reg + 4'd1;
      end
      WAIT: begin
        count_next   = total;
        wr_en_next   = 1'b1;
        wr_addr_next = cell_reg;
        wr_data_next = (total == 4'd3) || (self_reg && (total == 4'd2));
        state_next   = WRITE;
      end
      WRITE: begin
        if (cell_reg == LAST_CELL) begin
          state_next = DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          gen_next   = gen_reg + 16'd1;
        end else begin
          state_next = READ;
          cell_next  = cell_reg + 13'd1;
          tap_next   = '0;
          count_next = '0;
          self_next  = 1'b0;
          if (x_reg == X_MAX) begin
            x_next = '0;
            y_next = y_reg + 1'b1;
          end else begin
            x_next = x_reg + 1'b1;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (state_next == READ)
      rd_addr_next = tap_addr(x_next, y_next, tap_next);
  end

  assign rd_addr   = rd_addr_reg;
  assign wr_en     = wr_en_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign gen_count = gen_reg;

endmodule

// File: tb/tb_state_writer.sv
// Directed bench for state_writer on a reduced 12x7 torus so each generation
// takes 11*84+1 = 925 cycles; a behavioural memory feeds and records the grid.
module tb_state_writer;
  localparam int W = 12;
  localparam int H = 7;
  localparam int N = W * H;
  localparam int GEN_CYC = 11 * N + 1;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        start = 1'b0;
  logic        rd_data = 1'b0;
  logic [12:0] rd_addr;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic        wr_data;
  logic        busy;
  logic        done;
  logic [15:0] gen_count;

  state_writer #(.GRID_W(W), .GRID_H(H)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .gen_count(gen_count)
  );

  always #5 aclk = ~aclk;

  bit cur[N];
  bit nxt[N];
  bit expg[N];
  int wr_cnt = 0;
  int order_bad = 0;
  int n_checks = 0;
  int n_fail = 0;
  int exp_gen = 0;
  logic [12:0] rd_log[10];
  logic [12:0] rd_at_done;
  logic done_after;

  // Synchronous-read current-generation memory
  always @(posedge aclk) rd_data <= (rd_addr < 13'(N)) ? cur[rd_addr] : 1'b0;

  // Next-generation memory; writes must arrive in address order
  always @(negedge aclk) begin
    if (wr_en === 1'b1) begin
      if (int'(wr_addr) != wr_cnt) order_bad++;
      if (wr_addr < 13'(N)) nxt[wr_addr] = wr_data;
      wr_cnt++;
    end
  end

  task automatic clear_grids();
    for (int i = 0; i < N; i++) begin
      cur[i] = 1'b0;
      nxt[i] = 1'b1;
      expg[i] = 1'b0;
    end
  endtask

  function automatic int bad_cells();
    int b = 0;
    for (int i = 0; i < N; i++) if (nxt[i] != expg[i]) b++;
    return b;
  endfunction

  function automatic bit life_ref(input int x, input int y);
    int n = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (dx != 0 || dy != 0) n += int'(cur[((y + dy + H) % H) * W + ((x + dx + W) % W)]);
    return (n == 3) || (cur[y * W + x] && n == 2);
  endfunction

  // Cycle 0 is the cycle in which start is high; loop samples each later cycle at negedge.
  task automatic run_gen(input int pulse_cyc, input bit pulse_done, output int done_cyc,
                         output int busy_cnt, output int busy_first, output int busy_last);
    int c;
    wr_cnt = 0; order_bad = 0;
    done_cyc = -1; busy_cnt = 0; busy_first = -1; busy_last = -1;
    @(negedge aclk) start = 1'b1;
    @(negedge aclk) start = 1'b0;
    c = 1;
    while (c < GEN_CYC + 100) begin
      if (c <= 9) rd_log[c] = rd_addr;
      if (busy === 1'b1) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
      start = (c == pulse_cyc);
      if (done === 1'b1) begin
        done_cyc = c;
        rd_at_done = rd_addr;
        start = pulse_done;
        break;
      end
      @(negedge aclk);
      c++;
    end
    @(negedge aclk);
    start = 1'b0;
    done_after = done;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    @(negedge aclk);
    n_checks++; if (rd_addr !== 13'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
    n_checks++; if (wr_addr !== 13'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
    n_checks++; if (wr_data !== 1'b0) begin n_fail++; $display("FAIL reset_wr_data: got %b expected 0", wr_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (gen_count !== 16'd0) begin n_fail++; $display("FAIL reset_gen_count: got %0d expected 0", gen_count); end
    aresetn = 1'b1;
    exp_gen = 0;
    $display("reset: outputs checked");
  endtask

  task automatic test_empty();
    int dc, bc, bf, bl;
    int exp_rd[10];
    // Cell 0 neighbours on the 12x7 torus: (11,6),(0,6),(1,6),(11,0),(0,0),(1,0),(11,1),(0,1),(1,1)
    exp_rd = '{0, 83, 72, 73, 11, 0, 1, 23, 12, 13};
    clear_grids();
    run_gen(0, 1'b0, dc, bc, bf, bl);
    exp_gen++;
    for (int k = 1; k <= 9; k++) begin
      n_checks++;
      if (int'(rd_log[k]) != exp_rd[k]) begin
        n_fail++; $display("FAIL empty_rd_addr_tap%0d: got %0d expected %0d", k - 1, rd_log[k], exp_rd[k]);
      end
    end
    n_checks++; if (dc != GEN_CYC) begin n_fail++; $display("FAIL empty_done_cycle: got %0d expected %0d", dc, GEN_CYC); end
    n_checks++; if (bc != GEN_CYC - 1) begin n_fail++; $display("FAIL empty_busy_cycles: got %0d expected %0d", bc, GEN_CYC - 1); end
    n_checks++; if (bf != 1) begin n_fail++; $display("FAIL empty_busy_first: got %0d expected 1", bf); end
    n_checks++; if (bl != GEN_CYC - 1) begin n_fail++; $display("FAIL empty_busy_last: got %0d expected %0d", bl, GEN_CYC - 1); end
    n_checks++; if (wr_cnt != N) begin n_fail++; $display("FAIL empty_write_count: got %0d expected %0d", wr_cnt, N); end
    n_checks++; if (order_bad != 0) begin n_fail++; $display("FAIL empty_write_order: got %0d out-of-order expected 0", order_bad); end
    n_checks++; if (bad_cells() != 0) begin n_fail++; $display("FAIL empty_grid: got %0d wrong cells expected 0", bad_cells()); end
    n_checks++; if (rd_at_done !== 13'd0) begin n_fail++; $display("FAIL empty_rd_addr_done: got %0d expected 0", rd_at_done); end
    n_checks++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL empty_done_width: got %b expected 0", done_after); end
    n_checks++; if (int'(gen_count) != exp_gen) begin n_fail++; $display("FAIL empty_gen_count: got %0d expected %0d", gen_count, exp_gen); end
    $display("empty: done at cycle %0d, %0d writes", dc, wr_cnt);
  endtask

  task automatic test_pattern(input string name, input int n_alive, input int ax[4], input int ay[4],
                              input int n_exp, input int ex[4], input int ey[4]);
    int dc, bc, bf, bl;
    clear_grids();
    for (int i = 0; i < n_alive; i++) cur[ay[i] * W + ax[i]] = 1'b1;
    for (int i = 0; i < n_exp; i++) expg[ey[i] * W + ex[i]] = 1'b1;
    run_gen(0, 1'b0, dc, bc, bf, bl);
    exp_gen++;
    n_checks++; if (bad_cells() != 0) begin n_fail++; $display("FAIL %s_grid: got %0d wrong cells expected 0", name, bad_cells()); end
    n_checks++; if (wr_cnt != N) begin n_fail++; $display("FAIL %s_write_count: got %0d expected %0d", name, wr_cnt, N); end
    n_checks++; if (dc != GEN_CYC) begin n_fail++; $display("FAIL %s_done_cycle: got %0d expected %0d", name, dc, GEN_CYC); end
    n_checks++; if (int'(gen_count) != exp_gen) begin n_fail++; $display("FAIL %s_gen_count: got %0d expected %0d", name, gen_count, exp_gen); end
    $display("%s: done at cycle %0d, gen_count %0d", name, dc, gen_count);
  endtask

  task automatic test_blinker();
    test_pattern("blinker", 3, '{4, 5, 6, 0}, '{3, 3, 3, 0}, 3, '{5, 5, 5, 0}, '{2, 3, 4, 0});
  endtask

  task automatic test_corner();
    test_pattern("corner", 4, '{0, 11, 0, 11}, '{0, 0, 6, 6}, 4, '{0, 11, 0, 11}, '{0, 0, 6, 6});
  endtask

  // Every cell alive: each has 8 live neighbours and dies.
  task automatic test_full();
    int dc, bc, bf, bl;
    clear_grids();
    for (int i = 0; i < N; i++) cur[i] = 1'b1;
    run_gen(0, 1'b0, dc, bc, bf, bl);
    exp_gen++;
    n_checks++; if (bad_cells() != 0) begin n_fail++; $display("FAIL full_grid: got %0d wrong cells expected 0", bad_cells()); end
    $display("full: done at cycle %0d", dc);
  endtask

  task automatic test_rule_table();
    int dc, bc, bf, bl;
    int dens[4];
    dens = '{15, 35, 60, 85};
    for (int t = 0; t < 4; t++) begin
      clear_grids();
      for (int i = 0; i < N; i++) cur[i] = ($urandom_range(99) < dens[t]);
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) expg[y * W + x] = life_ref(x, y);
      run_gen(0, 1'b0, dc, bc, bf, bl);
      exp_gen++;
      n_checks++;
      if (bad_cells() != 0) begin n_fail++; $display("FAIL rule_density%0d: got %0d wrong cells expected 0", dens[t], bad_cells()); end
      $display("rule: density %0d%% done at cycle %0d", dens[t], dc);
    end
  endtask

  task automatic test_reset_mid();
    int dc, bc, bf, bl, w_at_reset;
    clear_grids();
    cur[5] = 1'b1; cur[6] = 1'b1; cur[7] = 1'b1;
    wr_cnt = 0; order_bad = 0;
    @(negedge aclk) start = 1'b1;
    @(negedge aclk) start = 1'b0;
    repeat (299) @(negedge aclk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
    #2 aresetn = 1'b0;
    #1;
    w_at_reset = wr_cnt;
    n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL midreset_wr_en: got %b expected 0", wr_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", done); end
    n_checks++; if (gen_count !== 16'd0) begin n_fail++; $display("FAIL midreset_gen_count: got %0d expected 0", gen_count); end
    n_checks++; if (rd_addr !== 13'd0) begin n_fail++; $display("FAIL midreset_rd_addr: got %0d expected 0", rd_addr); end
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    exp_gen = 0;
    repeat (30) @(negedge aclk);
    n_checks++; if (wr_cnt != w_at_reset) begin n_fail++; $display("FAIL midreset_no_writes: got %0d writes expected %0d", wr_cnt, w_at_reset); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got busy %b expected 0", busy); end
    for (int i = 0; i < N; i++) expg[i] = 1'b0;
    expg[6] = 1'b1; expg[W + 6] = 1'b1; expg[(H - 1) * W + 6] = 1'b1;
    run_gen(0, 1'b0, dc, bc, bf, bl);
    exp_gen++;
    n_checks++; if (dc != GEN_CYC) begin n_fail++; $display("FAIL midreset_restart_cycle: got %0d expected %0d", dc, GEN_CYC); end
    n_checks++; if (order_bad != 0 || wr_cnt != N) begin n_fail++; $display("FAIL midreset_restart_writes: got %0d writes %0d misordered expected %0d 0", wr_cnt, order_bad, N); end
    n_checks++; if (bad_cells() != 0) begin n_fail++; $display("FAIL midreset_restart_grid: got %0d wrong cells expected 0", bad_cells()); end
    n_checks++; if (int'(gen_count) != exp_gen) begin n_fail++; $display("FAIL midreset_gen_count: got %0d expected %0d", gen_count, exp_gen); end
    $display("reset_mid: %0d writes before reset, restart done at cycle %0d", w_at_reset, dc);
  endtask

  task automatic test_start_ignored();
    int dc, bc, bf, bl;
    clear_grids();
    run_gen(50, 1'b1, dc, bc, bf, bl);
    exp_gen++;
    n_checks++; if (dc != GEN_CYC) begin n_fail++; $display("FAIL ignore_done_cycle: got %0d expected %0d", dc, GEN_CYC); end
    n_checks++; if (wr_cnt != N || order_bad != 0) begin n_fail++; $display("FAIL ignore_writes: got %0d writes %0d misordered expected %0d 0", wr_cnt, order_bad, N); end
    repeat (10) @(negedge aclk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_done_start: got busy %b expected 0", busy); end
    n_checks++; if (int'(gen_count) != exp_gen) begin n_fail++; $display("FAIL ignore_gen_count: got %0d expected %0d", gen_count, exp_gen); end
    $display("start_ignored: done at cycle %0d, gen_count %0d", dc, gen_count);
  endtask

  initial begin
    #1;
    test_reset();
    test_empty();
    test_blinker();
    test_corner();
    test_full();
    test_rule_table();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
